// File: rtl/store_pkg.sv
// Shared types and constants for the store narrowing path (16-bit register -> 8-bit memory).
// Optional saturation of out-of-range byte stores is enabled with STORE_SATURATE_EN.
package store_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] BYTE_MAX  = 8'h7F;
  localparam logic [7:0] BYTE_MIN  = 8'h80;

  localparam logic       MODE_WORD = 1'b0;
  localparam logic       MODE_BYTE = 1'b1;

endpackage

// File: rtl/narrow_check.sv
// Dual of the 8->16 sign extender: a 16-bit value fits in 8 bits only if it is
// the sign extension of its own low byte; sat8 clamps it to the signed byte range.
module narrow_check
  import store_pkg::*;
(
  input  logic [15:0] value,
  output logic        fits8,
  output logic [7:0]  sat8
);

  logic [7:0] upper_match;

  // Every upper bit must replicate bit 7 for the value to be representable.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper
      assign upper_match[gi] = (value[8 + gi] == value[7]);
    end
  endgenerate

  assign fits8 = &upper_match;

  always_comb begin
    sat8 = value[7:0];
    if (!fits8) begin
      sat8 = value[15] ? BYTE_MIN : BYTE_MAX;
    end
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store-side narrowing unit: writes a 16-bit register as two little-endian bytes or
// as a single checked byte. Macro STORE_SATURATE_EN clamps overflowing byte stores.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_data,
  input  logic              req_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              ovf
);

`ifdef STORE_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        hi_byte_reg;
  logic              byte_reg;

  logic              fits8;
  logic [7:0]        sat8;
  logic [7:0]        lo_byte_next;

  narrow_check u_narrow_check (
    .value (req_data),
    .fits8 (fits8),
    .sat8  (sat8)
  );

  // The low byte is decided at accept time so LO can drive it straight from a register.
  assign lo_byte_next = (SAT_EN && (req_byte == MODE_BYTE) && !fits8) ? sat8 : req_data[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      req_ready   <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      addr_reg    <= '0;
      hi_byte_reg <= '0;
      byte_reg    <= MODE_WORD;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg    <= req_addr;
            hi_byte_reg <= req_data[15:8];
            byte_reg    <= req_byte;
            ovf         <= (req_byte == MODE_BYTE) && !fits8;
            req_ready   <= 1'b0;
            mem_we      <= 1'b1;
            mem_addr    <= req_addr;
            mem_wdata   <= lo_byte_next;
            state_reg   <= LO;
          end
        end
        LO: begin
          if (mem_ack) begin
            if (byte_reg == MODE_BYTE) begin
              mem_we    <= 1'b0;
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              // Upper byte goes to the next address; the add wraps at the top of memory.
              mem_addr  <= addr_reg + ADDR_W'(1);
              mem_wdata <= hi_byte_reg;
              state_reg <= HI;
            end
          end
        end
        HI: begin
          if (mem_ack) begin
            mem_we    <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          mem_we    <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit against a value-level model of the store rules.
// Honours STORE_SATURATE_EN the same way the design does.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [15:0] req_data;
  logic        req_byte;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        ovf;

  int tests_run = 0;
  int fails = 0;

  // Observations collected by run_store
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         lat;
  int         unstable;
  int         busy_ready;
  logic       obs_ovf;
  logic       done_after;
  logic       ready_after;
  logic       accept_ready;
  bit         timed_out;

  // Model expectations
  int         exp_n;
  logic [7:0] exp_a[2];
  logic [7:0] exp_d[2];
  logic       exp_ovf;
  int         exp_lat;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_byte  (req_byte),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .ovf       (ovf)
  );

  // Value-level model: a byte store overflows when the signed value leaves [-128, 127].
  function automatic void model(input logic [7:0] a, input logic [15:0] d, input logic b,
                                input int lo_w, input int hi_w);
    int v;
    v = $signed(d);
    exp_ovf = b && (v > 127 || v < -128);
    exp_n   = b ? 1 : 2;
    exp_a[0] = a;
    exp_d[0] = d[7:0];
`ifdef STORE_SATURATE_EN
    if (b && v > 127)  exp_d[0] = 8'h7F;
    if (b && v < -128) exp_d[0] = 8'h80;
`endif
    exp_a[1] = 8'((int'(a) + 1) % 256);
    exp_d[1] = d[15:8];
    exp_lat  = b ? (2 + lo_w) : (3 + lo_w + hi_w);
  endfunction

  // Issues one store, answers mem_we with acks after the given wait counts, records what happens.
  task automatic run_store(input logic [7:0] a, input logic [15:0] d, input logic b,
                           input int lo_w, input int hi_w, input bit poke);
    int   wait_cnt;
    int   need;
    logic pending;
    logic [7:0] hold_a;
    logic [7:0] hold_d;
    wr_addr_q.delete();
    wr_data_q.delete();
    lat = -1; unstable = 0; busy_ready = 0; timed_out = 0;
    obs_ovf = 1'b0; done_after = 1'bx; ready_after = 1'bx;
    wait_cnt = 0; pending = 1'b0; hold_a = '0; hold_d = '0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_byte = b; mem_ack = 1'b0;
    accept_ready = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 8'($urandom); req_data = 16'($urandom); req_byte = 1'($urandom);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (done) begin
        lat = cyc;
        obs_ovf = ovf;
        break;
      end
      if (req_ready) busy_ready++;
      if (pending && (mem_addr !== hold_a || mem_wdata !== hold_d)) unstable++;
      if (mem_we) begin
        need = (wr_addr_q.size() == 0) ? lo_w : hi_w;
        if (wait_cnt >= need) begin
          mem_ack = 1'b1;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
          wait_cnt = 0;
          pending = 1'b0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
          pending = 1'b1;
          hold_a = mem_addr;
          hold_d = mem_wdata;
          if (poke && wr_addr_q.size() == 0 && wait_cnt == 1) begin
            req_valid = 1'b1; req_addr = 8'h55; req_data = 16'h7777; req_byte = 1'b0;
          end
        end
      end else begin
        mem_ack = 1'b0;
        pending = 1'b0;
      end
    end
    mem_ack = 1'b0;
    if (lat < 0) begin
      timed_out = 1'b1;
    end else begin
      @(negedge clk);
      done_after = done;
      ready_after = req_ready;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b1; req_addr = 8'hC3; req_data = 16'hFFFF; req_byte = 1'b1; mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    tests_run++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    tests_run++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got=%h want=00", mem_addr); end
    tests_run++; if (mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_mem_wdata got=%h want=00", mem_wdata); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
    tests_run++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    req_valid = 1'b0; mem_ack = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset checked");
  endtask

  task automatic test_directed;
    logic [7:0]  ta[5];
    logic [15:0] td[5];
    logic        tb_[5];
    ta = '{8'h10, 8'h20, 8'h30, 8'hFF, 8'h40};
    td = '{16'hBEEF, 16'hFF85, 16'h0085, 16'h1234, 16'h8000};
    tb_ = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      model(ta[k], td[k], tb_[k], 0, 0);
      run_store(ta[k], td[k], tb_[k], 0, 0, 1'b0);
      $display("[TB] directed addr=%h data=%h byte=%b writes=%0d lat=%0d ovf=%b", ta[k], td[k], tb_[k], wr_addr_q.size(), lat, obs_ovf);
      tests_run++; if (timed_out || !accept_ready) begin fails++; $display("FAIL dir%0d_complete timeout=%b ready=%b want 0/1", k, timed_out, accept_ready); end
      tests_run++; if (wr_addr_q.size() != exp_n) begin fails++; $display("FAIL dir%0d_count got=%0d want=%0d", k, wr_addr_q.size(), exp_n); end
      for (int i = 0; i < exp_n; i++) begin
        if (i < wr_addr_q.size()) begin
          tests_run++;
          if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
            fails++; $display("FAIL dir%0d_write%0d got=%h@%h want=%h@%h", k, i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
          end
        end
      end
      tests_run++; if (lat != exp_lat) begin fails++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, exp_lat); end
      tests_run++; if (obs_ovf !== exp_ovf) begin fails++; $display("FAIL dir%0d_ovf got=%b want=%b", k, obs_ovf, exp_ovf); end
      tests_run++; if (done_after !== 1'b0 || ready_after !== 1'b1) begin fails++; $display("FAIL dir%0d_pulse done_after=%b ready_after=%b want 0/1", k, done_after, ready_after); end
    end
  endtask

  task automatic test_wait_states;
    model(8'h80, 16'hA55A, 1'b0, 3, 2);
    run_store(8'h80, 16'hA55A, 1'b0, 3, 2, 1'b1);
    $display("[TB] wait addr=80 data=a55a writes=%0d lat=%0d unstable=%0d", wr_addr_q.size(), lat, unstable);
    tests_run++; if (timed_out) begin fails++; $display("FAIL wait_complete timeout=%b want=0", timed_out); end
    tests_run++; if (unstable != 0) begin fails++; $display("FAIL wait_stable got=%0d changes want=0", unstable); end
    tests_run++; if (busy_ready != 0) begin fails++; $display("FAIL wait_ready_busy got=%0d ready cycles want=0", busy_ready); end
    tests_run++; if (wr_addr_q.size() != exp_n) begin fails++; $display("FAIL wait_count got=%0d want=%0d", wr_addr_q.size(), exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      if (i < wr_addr_q.size()) begin
        tests_run++;
        if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
          fails++; $display("FAIL wait_write%0d got=%h@%h want=%h@%h", i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
        end
      end
    end
    tests_run++; if (lat != exp_lat) begin fails++; $display("FAIL wait_latency got=%0d want=%0d", lat, exp_lat); end
    // The poked request must not have been taken: the unit stays idle afterwards.
    @(negedge clk);
    tests_run++; if (mem_we !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL wait_poke_ignored mem_we=%b req_ready=%b want 0/1", mem_we, req_ready); end
  endtask

  task automatic test_reset_mid;
    int seen_done;
    int seen_we;
    seen_done = 0; seen_we = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'hA0; req_data = 16'hCAFE; req_byte = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    tests_run++; if (mem_we !== 1'b1 || mem_addr !== 8'hA1 || mem_wdata !== 8'hCA) begin
      fails++; $display("FAIL rstmid_hi got we=%b %h@%h want 1 ca@a1", mem_we, mem_wdata, mem_addr);
    end
    reset = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    tests_run++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rstmid_we got=%b want=0", mem_we); end
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready got=%b want=1", req_ready); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL rstmid_done got=%b want=0", done); end
    reset = 1'b0; mem_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen_done++;
      if (mem_we) seen_we++;
    end
    tests_run++; if (seen_done != 0 || seen_we != 0) begin fails++; $display("FAIL rstmid_quiet done=%0d we=%0d want 0/0", seen_done, seen_we); end
    model(8'h07, 16'hFF80, 1'b1, 1, 0);
    run_store(8'h07, 16'hFF80, 1'b1, 1, 0, 1'b0);
    $display("[TB] reset-mid recovery writes=%0d lat=%0d", wr_addr_q.size(), lat);
    tests_run++; if (timed_out || wr_addr_q.size() != exp_n) begin fails++; $display("FAIL rstmid_recover timeout=%b count=%0d want 0/%0d", timed_out, wr_addr_q.size(), exp_n); end
    else begin
      tests_run++; if (wr_addr_q[0] !== exp_a[0] || wr_data_q[0] !== exp_d[0]) begin
        fails++; $display("FAIL rstmid_recover_write got=%h@%h want=%h@%h", wr_data_q[0], wr_addr_q[0], exp_d[0], exp_a[0]);
      end
    end
    tests_run++; if (lat != exp_lat || obs_ovf !== exp_ovf) begin fails++; $display("FAIL rstmid_recover_lat got=%0d/%b want=%0d/%b", lat, obs_ovf, exp_lat, exp_ovf); end
  endtask

  task automatic test_random;
    logic [7:0]  a;
    logic [15:0] d;
    logic [7:0]  r;
    logic        b;
    int          lw;
    int          hw;
    for (int k = 0; k < 24; k++) begin
      a = 8'($urandom);
      r = 8'($urandom);
      d = ($urandom_range(0, 1) == 0) ? {{8{r[7]}}, r} : 16'($urandom);
      b = 1'($urandom);
      lw = $urandom_range(0, 2);
      hw = $urandom_range(0, 2);
      model(a, d, b, lw, hw);
      run_store(a, d, b, lw, hw, 1'b0);
      $display("[TB] random%0d addr=%h data=%h byte=%b waits=%0d/%0d writes=%0d lat=%0d ovf=%b", k, a, d, b, lw, hw, wr_addr_q.size(), lat, obs_ovf);
      tests_run++; if (timed_out || wr_addr_q.size() != exp_n) begin fails++; $display("FAIL rnd%0d_count timeout=%b got=%0d want=%0d", k, timed_out, wr_addr_q.size(), exp_n); end
      for (int i = 0; i < exp_n; i++) begin
        if (i < wr_addr_q.size()) begin
          tests_run++;
          if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== exp_d[i]) begin
            fails++; $display("FAIL rnd%0d_write%0d got=%h@%h want=%h@%h", k, i, wr_data_q[i], wr_addr_q[i], exp_d[i], exp_a[i]);
          end
        end
      end
      tests_run++; if (lat != exp_lat) begin fails++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, lat, exp_lat); end
      tests_run++; if (obs_ovf !== exp_ovf) begin fails++; $display("FAIL rnd%0d_ovf got=%b want=%b", k, obs_ovf, exp_ovf); end
      tests_run++; if (unstable != 0 || busy_ready != 0) begin fails++; $display("FAIL rnd%0d_hold unstable=%0d ready_busy=%0d want 0/0", k, unstable, busy_ready); end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_byte = 1'b0; mem_ack = 1'b0;
    test_reset();
    test_directed();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
